// File: rtl/moore_vender.sv
// rtl/moore_vender.sv - Moore vending controller: 25c can, nickel/dime/quarter in, dime/nickel change out
module moore_vender (
    input  logic       nickel,
    input  logic       dime,
    input  logic       quarter,
    output logic       DispatchCan,
    output logic       DispatchDime,
    output logic       DispatchNickel,
    input  logic       clk,
    input  logic       reset_b,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S0  = 4'd0,
        S5  = 4'd1,
        S10 = 4'd2,
        S15 = 4'd3,
        S20 = 4'd4,
        D25 = 4'd5,
        D30 = 4'd6,
        D35 = 4'd7,
        D40 = 4'd8,
        D45 = 4'd9,
        C10 = 4'd10
    } state_t;

    state_t     cur_state;
    state_t     nxt_state;
    logic [3:0] coin_nickels;

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            cur_state <= S0;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Codes S0..D45 equal accumulated credit in nickels, so crediting is a plain add.
    always_comb begin
        coin_nickels = 4'd0;
        if (quarter) begin
            coin_nickels = 4'd5;
        end else if (dime) begin
            coin_nickels = 4'd2;
        end else if (nickel) begin
            coin_nickels = 4'd1;
        end
    end

    always_comb begin
        nxt_state      = S0;
        DispatchCan    = 1'b0;
        DispatchDime   = 1'b0;
        DispatchNickel = 1'b0;
        case (cur_state)
            S0, S5, S10, S15, S20: nxt_state = state_t'(cur_state + coin_nickels);
            D25: begin
                DispatchCan = 1'b1;
            end
            D30: begin
                DispatchCan    = 1'b1;
                DispatchNickel = 1'b1;
            end
            D35: begin
                DispatchCan  = 1'b1;
                DispatchDime = 1'b1;
            end
            D40: begin
                DispatchCan    = 1'b1;
                DispatchDime   = 1'b1;
                DispatchNickel = 1'b1;
            end
            D45: begin
                DispatchCan  = 1'b1;
                DispatchDime = 1'b1;
                nxt_state    = C10;
            end
            C10: begin
                DispatchDime = 1'b1;
            end
            default: nxt_state = S0;
        endcase
    end

    assign state = cur_state;

endmodule

// File: tb/tb_moore_vender.sv
// tb/tb_moore_vender.sv - directed self-checking bench for moore_vender
module tb_moore_vender;

    logic       clk;
    logic       reset_b;
    logic       nickel;
    logic       dime;
    logic       quarter;
    logic       DispatchCan;
    logic       DispatchDime;
    logic       DispatchNickel;
    logic [3:0] state;

    int checks;
    int errors;

    moore_vender dut (
        .nickel         (nickel),
        .dime           (dime),
        .quarter        (quarter),
        .DispatchCan    (DispatchCan),
        .DispatchDime   (DispatchDime),
        .DispatchNickel (DispatchNickel),
        .clk            (clk),
        .reset_b        (reset_b),
        .state          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, clock it, then check state and the {can,dime,nickel} outputs.
    task automatic step(input string tag, input logic rb, input logic n, input logic d, input logic q,
                        input logic [3:0] exp_state, input logic [2:0] exp_out);
        @(negedge clk);
        reset_b = rb;
        nickel  = n;
        dime    = d;
        quarter = q;
        @(posedge clk);
        #1;
        check_eq({tag, "_state"}, {4'd0, state}, {4'd0, exp_state});
        check_eq({tag, "_out"}, {5'd0, DispatchCan, DispatchDime, DispatchNickel}, {5'd0, exp_out});
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_b = 1'b0;
        nickel  = 1'b0;
        dime    = 1'b0;
        quarter = 1'b0;

        // reset hold with coins toggling, then release idle
        step("rst0", 0, 1, 0, 1, 4'd0, 3'b000);
        step("rst1", 0, 0, 1, 0, 4'd0, 3'b000);
        step("rel",  1, 0, 0, 0, 4'd0, 3'b000);

        // nickel, dime, nickel, quarter -> D45 then C10
        step("mix_n1", 1, 1, 0, 0, 4'd1,  3'b000);
        step("mix_d",  1, 0, 1, 0, 4'd3,  3'b000);
        step("mix_n2", 1, 1, 0, 0, 4'd4,  3'b000);
        step("mix_q",  1, 0, 0, 1, 4'd9,  3'b110);
        step("mix_c",  1, 0, 0, 0, 4'd10, 3'b010);
        step("mix_s0", 1, 0, 0, 0, 4'd0,  3'b000);

        // exact price with five nickels
        step("ex1", 1, 1, 0, 0, 4'd1, 3'b000);
        step("ex2", 1, 1, 0, 0, 4'd2, 3'b000);
        step("ex3", 1, 1, 0, 0, 4'd3, 3'b000);
        step("ex4", 1, 1, 0, 0, 4'd4, 3'b000);
        step("ex5", 1, 1, 0, 0, 4'd5, 3'b100);
        step("ex6", 1, 0, 0, 0, 4'd0, 3'b000);

        // change cases
        step("q0",    1, 0, 0, 1, 4'd5, 3'b100);
        step("q0_r",  1, 0, 0, 0, 4'd0, 3'b000);
        step("c5_n",  1, 1, 0, 0, 4'd1, 3'b000);
        step("q5",    1, 0, 0, 1, 4'd6, 3'b101);
        step("q5_r",  1, 0, 0, 0, 4'd0, 3'b000);
        step("c10_d", 1, 0, 1, 0, 4'd2, 3'b000);
        step("q10",   1, 0, 0, 1, 4'd7, 3'b110);
        step("q10_r", 1, 0, 0, 0, 4'd0, 3'b000);
        step("c15_d", 1, 0, 1, 0, 4'd2, 3'b000);
        step("c15_n", 1, 1, 0, 0, 4'd3, 3'b000);
        step("q15",   1, 0, 0, 1, 4'd8, 3'b111);
        step("q15_r", 1, 0, 0, 0, 4'd0, 3'b000);

        // simultaneous coins, then coin ignored while dispensing
        step("all3",   1, 1, 1, 1, 4'd5, 3'b100);
        step("ign_d",  1, 0, 1, 0, 4'd0, 3'b000);
        step("dn_pri", 1, 1, 1, 0, 4'd2, 3'b000);
        step("dn_r",   1, 0, 0, 0, 4'd2, 3'b000);
        step("dn_d",   1, 0, 1, 0, 4'd4, 3'b000);
        step("d45",    1, 0, 0, 1, 4'd9, 3'b110);
        step("c10ign", 1, 1, 1, 1, 4'd10, 3'b010);
        step("c10out", 1, 0, 0, 0, 4'd0, 3'b000);

        // reset aborts D45 before the C10 dime
        step("r_d1",  1, 0, 1, 0, 4'd2, 3'b000);
        step("r_d2",  1, 0, 1, 0, 4'd4, 3'b000);
        step("r_q",   1, 0, 0, 1, 4'd9, 3'b110);
        step("r_abt", 0, 0, 0, 0, 4'd0, 3'b000);
        step("r_rel", 1, 0, 0, 0, 4'd0, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/moore_vender.md
Name: moore_vender

Overview:
Moore-style vending-machine controller that accepts nickel (5c), dime (10c) and quarter (25c) coin pulses. It dispenses one can priced 25c and returns change as dime/nickel dispatch pulses. All outputs are decoded from the registered state only. The block sits between the coin-acceptor pulse logic and the can/change dispenser actuators, and exposes its state code for debug.

Parameters:
None. Price is fixed at 25c and the state encoding is fixed as listed in Behaviour.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset_b  input  1  synchronous active-low reset
nickel  input  1  5c coin present this cycle (sampled each rising edge)
dime  input  1  10c coin present this cycle
quarter  input  1  25c coin present this cycle
DispatchCan  output  1  dispense one can (high for one cycle per dispense state)
DispatchDime  output  1  return one dime
DispatchNickel  output  1  return one nickel
state  output  4  current state code (debug)

Behaviour:
- Port order: nickel, dime, quarter, DispatchCan, DispatchDime, DispatchNickel, clk, reset_b, state.
- Reset: reset_b=0 at a rising edge -> state=S0. In S0 all Dispatch* outputs are 0. Reset takes priority over any coin input and aborts any dispense or change sequence mid-operation.
- Coin input is a level sampled every rising edge. A coin held high for N cycles counts as N coins.
- Simultaneous coins: only one coin counts per cycle, with priority quarter > dime > nickel. Lower-priority coins in that cycle are ignored.
- State codes:
  - Credit states: S0=0, S5=1, S10=2, S15=3, S20=4.
  - Dispense states: D25=5, D30=6, D35=7, D40=8, D45=9.
  - Change state: C10=10.
- Credit-state transitions:
  - From credit c in {0,5,10,15,20}, the next state corresponds to c+coin.
  - A total below 25 goes to credit state S(total).
  - A total of 25 or more goes to D(total).
  - Maximum total is 20+25 = 45.
  - No coin -> stay in the current state.
- Dispense and change states last exactly one cycle:
  - D25, D30, D35, D40 -> S0.
  - D45 -> C10.
  - C10 -> S0.
  - Coins sampled while in any dispense or change state are ignored (not credited).
- Outputs are a function of state only (Moore), valid the cycle after the deciding edge, i.e. 1-cycle latency from the coin cycle:
  - D25: Can=1.
  - D30: Can=1, Nickel=1.
  - D35: Can=1, Dime=1.
  - D40: Can=1, Dime=1, Nickel=1.
  - D45: Can=1, Dime=1.
  - C10: Dime=1.
  - All other states: all Dispatch* = 0.
- Total change returned always equals credit minus 25.
- Illegal codes 11-15: all outputs 0, next state S0.
- state output equals the state register.

Test Plan:
- Reset hold: reset_b=0 for 2 edges with coins toggling -> state=0 and all Dispatch*=0. Release reset with no coins -> state stays 0.
- Mixed sequence, one coin per cycle: nickel, dime, nickel, quarter -> state 1, 3, 4, 9 (Can=1, Dime=1), then 10 (Dime=1 only), then 0.
- Exact price: five consecutive nickel cycles -> states 1, 2, 3, 4, 5. In state 5 Can=1 with no change, next state 0.
- Change cases:
  - From S0: quarter -> D25.
  - From S5: quarter -> D30 (Can+Nickel).
  - From S10: quarter -> D35 (Can+Dime).
  - From S15: quarter -> D40 (Can+Dime+Nickel).
  - Each returns to 0 the following cycle.
- Simultaneous/ignored coins:
  - nickel=dime=quarter=1 in S0 -> D25.
  - Dime asserted during D25 -> next state 0 (dime not credited).
- Reset mid-sequence: reach D45, assert reset_b=0 at the next edge -> state 0, no C10 dime pulse.
